// File: rtl/homography_bilinear_sampler.sv
// Bilinear sampler: fetches the 2x2 source neighbourhood of one coordinate
// and emits a single blended pixel, with valid/ready on both sides.
module homography_bilinear_sampler #(
    parameter int DATA_WIDTH  = 8,
    parameter int COORD_WIDTH = 16,
    parameter int FRAC_WIDTH  = 16,
    parameter int WEIGHT_BITS = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   coord_valid,
    output logic                   coord_ready,
    input  logic [COORD_WIDTH-1:0] src_x,
    input  logic [COORD_WIDTH-1:0] src_y,
    input  logic [FRAC_WIDTH-1:0]  src_x_frac,
    input  logic [FRAC_WIDTH-1:0]  src_y_frac,
    input  logic [COORD_WIDTH-1:0] src_width,
    input  logic [COORD_WIDTH-1:0] src_height,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    output logic                   pix_valid,
    output logic [DATA_WIDTH-1:0]  pix_data,
    input  logic                   pix_ready
);

    localparam int CW  = COORD_WIDTH;
    localparam int WB  = WEIGHT_BITS;
    localparam int PW  = 2 * CW + 1;
    localparam int IW  = DATA_WIDTH + 2 * WB + 1;
    localparam int W   = 1 << WB;
    localparam int RND = 1 << (2 * WB - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, BLEND, OUT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           x_q, y_q, w_q, h_q;
    logic [WB-1:0]           fx_q, fy_q;
    logic [1:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   pix_q;
    logic [DATA_WIDTH-1:0]   p_q [4];
    logic                    tv_q [MEM_LATENCY];
    logic [1:0]              ti_q [MEM_LATENCY];

    logic                    in_range, accept, ret_last;
    logic [CW:0]             xp1, yp1;
    logic [CW-1:0]           x1, y1, x_sel, y_sel;
    logic [PW-1:0]           prod;
    logic [ADDR_WIDTH-1:0]   addr_now;
    logic [IW-1:0]           fxw, fyw, wfx, wfy, top, bot, acc;
    logic [DATA_WIDTH-1:0]   blend;
    logic                    unused_ok;

    assign in_range = (src_x < src_width) && (src_y < src_height);
    assign accept   = coord_ready && coord_valid;
    assign ret_last = tv_q[MEM_LATENCY-1] && (ti_q[MEM_LATENCY-1] == 2'd3);

    // Neighbour coordinates clamp to the last row/column at the frame edge.
    assign xp1   = {1'b0, x_q} + (CW+1)'(1);
    assign yp1   = {1'b0, y_q} + (CW+1)'(1);
    assign x1    = (xp1 >= {1'b0, w_q}) ? x_q : xp1[CW-1:0];
    assign y1    = (yp1 >= {1'b0, h_q}) ? y_q : yp1[CW-1:0];
    assign x_sel = cnt_q[0] ? x1 : x_q;
    assign y_sel = cnt_q[1] ? y1 : y_q;
    assign prod  = PW'(y_sel) * PW'(w_q) + PW'(x_sel);
    assign addr_now = prod[ADDR_WIDTH-1:0];

    always_comb begin
        fxw   = IW'(fx_q);
        fyw   = IW'(fy_q);
        wfx   = IW'(W) - fxw;
        wfy   = IW'(W) - fyw;
        top   = IW'(p_q[0]) * wfx + IW'(p_q[1]) * fxw;
        bot   = IW'(p_q[2]) * wfx + IW'(p_q[3]) * fxw;
        acc   = top * wfy + bot * fyw + IW'(RND);
        blend = acc[2*WB +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        coord_ready = 1'b0;
        mem_rd_en   = 1'b0;
        pix_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                coord_ready = !rst;
                if (coord_valid) state_d = in_range ? FETCH : OUT;
            end
            FETCH: begin
                mem_rd_en = !rst;
                if (cnt_q == 2'd3) state_d = WAIT;
            end
            WAIT:  if (ret_last) state_d = BLEND;
            BLEND: state_d = OUT;
            OUT: begin
                pix_valid = 1'b1;
                if (pix_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_addr = mem_rd_en ? addr_now : addr_q;
    assign pix_data    = pix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            addr_q <= '0;
            pix_q  <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) tv_q[k] <= 1'b0;
        end else begin
            if (accept) begin
                x_q   <= src_x;
                y_q   <= src_y;
                w_q   <= src_width;
                h_q   <= src_height;
                fx_q  <= src_x_frac[FRAC_WIDTH-1 -: WB];
                fy_q  <= src_y_frac[FRAC_WIDTH-1 -: WB];
                cnt_q <= 2'd0;
                if (!in_range) pix_q <= '0;
            end
            if (mem_rd_en) begin
                cnt_q  <= cnt_q + 2'd1;
                addr_q <= addr_now;
            end
            // Tag pipe mirrors the memory latency so each return finds its slot.
            tv_q[0] <= mem_rd_en;
            ti_q[0] <= cnt_q;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                tv_q[k] <= tv_q[k-1];
                ti_q[k] <= ti_q[k-1];
            end
            if (tv_q[MEM_LATENCY-1]) p_q[ti_q[MEM_LATENCY-1]] <= mem_rd_data;
            if (state_q == BLEND) pix_q <= blend;
        end
    end

    assign unused_ok = ^{src_x_frac, src_y_frac, prod, acc};

endmodule

// File: tb/tb_homography_bilinear_sampler.sv
// Directed and random checks of the bilinear sampler against a
// behavioural memory and blend model.
module tb_homography_bilinear_sampler;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int FW = 16;
    localparam int WB = 8;
    localparam int AW = 20;
    localparam int L  = 2;

    logic          clk = 0;
    logic          rst = 1;
    logic          coord_valid = 0;
    logic          coord_ready;
    logic [CW-1:0] src_x = 0, src_y = 0, src_width = 0, src_height = 0;
    logic [FW-1:0] src_x_frac = 0, src_y_frac = 0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready = 1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mode = 0;
    int memv [int];
    logic [DW-1:0] rpipe [L];

    homography_bilinear_sampler #(
        .DATA_WIDTH(DW), .COORD_WIDTH(CW), .FRAC_WIDTH(FW),
        .WEIGHT_BITS(WB), .ADDR_WIDTH(AW), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .coord_valid(coord_valid), .coord_ready(coord_ready),
        .src_x(src_x), .src_y(src_y),
        .src_x_frac(src_x_frac), .src_y_frac(src_y_frac),
        .src_width(src_width), .src_height(src_height),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rdmem(input int a);
        int v;
        if (memv.exists(a)) return memv[a];
        if (mode == 0) v = a;
        else v = a * 29 + 11;
        return v & 255;
    endfunction

    // Memory: data for a read strobed in cycle c is presented in cycle c+L.
    always @(posedge clk) begin
        rpipe[0] <= mem_rd_en ? DW'(rdmem(int'(mem_rd_addr))) : 8'hA5;
        for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rd_data = rpipe[L-1];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int x, input int y, input int fxr, input int fyr,
                       input int w, input int h, input int hold, input string nm);
        int t0, voff, x1, y1, fx, fy, ex, top, bot;
        int ea [4];
        int a [$];
        int off [$];
        bit inr, seen;
        inr = (x < w) && (y < h);
        x1 = (x + 1 >= w) ? x : x + 1;
        y1 = (y + 1 >= h) ? y : y + 1;
        ea[0] = (y * w + x) % (1 << AW);
        ea[1] = (y * w + x1) % (1 << AW);
        ea[2] = (y1 * w + x) % (1 << AW);
        ea[3] = (y1 * w + x1) % (1 << AW);
        fx = fxr >> (FW - WB);
        fy = fyr >> (FW - WB);
        top = rdmem(ea[0]) * (256 - fx) + rdmem(ea[1]) * fx;
        bot = rdmem(ea[2]) * (256 - fx) + rdmem(ea[3]) * fx;
        ex = inr ? (top * (256 - fy) + bot * fy + 32768) / 65536 : 0;

        @(negedge clk);
        check({nm, ".ready"}, coord_ready, 1);
        src_x = CW'(x); src_y = CW'(y);
        src_x_frac = FW'(fxr); src_y_frac = FW'(fyr);
        src_width = CW'(w); src_height = CW'(h);
        pix_ready = (hold == 0);
        coord_valid = 1;
        t0 = cyc;
        @(negedge clk);
        coord_valid = 0;
        seen = 0;
        voff = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (mem_rd_en) begin
                a.push_back(int'(mem_rd_addr));
                off.push_back(cyc - t0);
            end
            if (pix_valid) begin
                seen = 1;
                voff = cyc - t0;
                break;
            end
        end
        check({nm, ".seen"}, seen, 1);
        check({nm, ".lat"}, voff, inr ? 6 + L : 1);
        check({nm, ".nrd"}, a.size(), inr ? 4 : 0);
        for (int k = 0; k < a.size() && k < 4; k++) begin
            check($sformatf("%s.addr%0d", nm, k), a[k], ea[k]);
            check($sformatf("%s.off%0d", nm, k), off[k], k + 1);
        end
        check({nm, ".data"}, pix_data, ex);
        for (int j = 0; j < hold; j++) begin
            check({nm, ".hold_v"}, pix_valid, 1);
            check({nm, ".hold_d"}, pix_data, ex);
            check({nm, ".hold_r"}, coord_ready, 0);
            @(negedge clk);
        end
        pix_ready = 1;
        @(negedge clk);
        check({nm, ".back_r"}, coord_ready, 1);
        check({nm, ".back_v"}, pix_valid, 0);
    endtask

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        check("rst.ready", coord_ready, 0);
        check("rst.rd_en", mem_rd_en, 0);
        check("rst.addr", mem_rd_addr, 0);
        check("rst.valid", pix_valid, 0);
        check("rst.data", pix_data, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst.ready", coord_ready, 1);

        mode = 0;
        run(3, 2, 0, 0, 8, 6, 0, "basic");

        memv[19] = 10; memv[20] = 20; memv[27] = 30; memv[28] = 40;
        run(3, 2, 32'h8000, 32'h8000, 8, 6, 0, "half");
        memv.delete();

        run(7, 5, 32'h1234, 32'hfedc, 8, 6, 0, "clamp");
        run(8, 2, 32'h4000, 32'h4000, 8, 6, 0, "oor_x");
        run(1, 6, 0, 0, 8, 6, 0, "oor_y");
        run(2, 1, 32'h3000, 32'hc000, 8, 6, 5, "bp");

        // Reset during the second fetch cycle.
        @(negedge clk);
        src_x = 3; src_y = 2; src_width = 8; src_height = 6;
        src_x_frac = 0; src_y_frac = 0;
        coord_valid = 1;
        @(negedge clk);
        coord_valid = 0;
        check("rstf.fetch1", mem_rd_en, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rstf.rd_off", mem_rd_en, 0);
        rst = 0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pix_valid) nv++;
        end
        check("rstf.no_valid", nv, 0);
        run(4, 3, 32'h6000, 32'h2000, 8, 6, 0, "after_rst");

        mode = 1;
        for (int i = 0; i < 10; i++) begin
            int w, h;
            w = $urandom_range(1, 20);
            h = $urandom_range(1, 20);
            run($urandom_range(0, w), $urandom_range(0, h),
                $urandom_range(0, 65535), $urandom_range(0, 65535),
                w, h, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/homography_bilinear_sampler.md
# homography_bilinear_sampler

Downstream consumer of the homography coordinate stage. Takes one source coordinate per transaction: integer `src_x`/`src_y` plus fractional parts. It issues four reads to the source frame buffer for the 2×2 neighbourhood, then emits one bilinearly blended output pixel. It sits between the coordinate pipeline and the output pixel stream, with valid/ready handshakes on both sides.

## Interface
- `DATA_WIDTH`, 8, pixel width (unsigned)
- `COORD_WIDTH`, 16, integer coordinate width
- `FRAC_WIDTH`, 16, fractional coordinate width
- `WEIGHT_BITS`, 8, blend weight precision; uses the top `WEIGHT_BITS` of each frac, must be ≤ `FRAC_WIDTH`
- `ADDR_WIDTH`, 20, frame buffer address width
- `MEM_LATENCY`, 2, read latency in cycles, must be ≥ 1
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `coord_valid`  in  1  coordinate present
- `coord_ready`  out  1  block can accept a coordinate
- `src_x`, `src_y`  in  `COORD_WIDTH`  integer source coordinate
- `src_x_frac`, `src_y_frac`  in  `FRAC_WIDTH`  fractional parts, unsigned, 0.FRAC_WIDTH format
- `src_width`, `src_height`  in  `COORD_WIDTH`  source frame size
- `mem_rd_en`  out  1  read strobe
- `mem_rd_addr`  out  `ADDR_WIDTH`  read address
- `mem_rd_data`  in  `DATA_WIDTH`  read data, valid exactly `MEM_LATENCY` cycles after the cycle `mem_rd_en` was high
- `pix_valid`  out  1  output pixel present
- `pix_data`  out  `DATA_WIDTH`  blended pixel
- `pix_ready`  in  1  downstream accepts pixel

## Operation
- FSM states: IDLE, FETCH, WAIT, BLEND, OUT.
- **IDLE**
  - `coord_ready`=1 only in IDLE.
  - On `coord_valid` the block latches the coordinate, fracs, width and height.
  - In range (`src_x`<`src_width` and `src_y`<`src_height`): go to FETCH.
  - Out of range: `pix_data`←0 and go to OUT; no reads are issued.
- **FETCH**
  - Issues 4 reads on consecutive cycles, in order p00 (x,y), p01 (x1,y), p10 (x,y1), p11 (x1,y1).
  - x1 = (x+1 ≥ width) ? x : x+1.
  - y1 = (y+1 ≥ height) ? y : y+1.
  - Address = y·width + x, computed at full precision and truncated to `ADDR_WIDTH`.
  - After the 4th read: go to WAIT.
- **WAIT**
  - A `MEM_LATENCY`-deep tag shift register captures returns into slots p00..p11.
  - When the p11 return is captured: go to BLEND.
- **BLEND** (one cycle, registered result)
  - fx, fy = top `WEIGHT_BITS` of each frac; W = 2^WEIGHT_BITS.
  - top = p00·(W−fx) + p01·fx.
  - bot = p10·(W−fy·0 + 0)… specifically bot = p10·(W−fx) + p11·fx.
  - `pix_data` = (top·(W−fy) + bot·fy + 2^(2·WEIGHT_BITS−1)) >> (2·WEIGHT_BITS).
  - Intermediates are at least `DATA_WIDTH`+2·`WEIGHT_BITS`+1 bits. The result never exceeds 2^DATA_WIDTH−1, so no saturation is needed.
  - Go to OUT.
- **OUT**
  - `pix_valid`=1 and `pix_data` held stable until `pix_ready`=1.
  - On handshake: go to IDLE in the next cycle.
- Reset, from any state including FETCH/WAIT:
  - FSM returns to IDLE and the tag register clears.
  - Returns from reads issued before reset are discarded and never produce `pix_valid`.

## Timing
- Reset values: `coord_ready`=0 while `rst`=1, then 1 from the first cycle after reset deasserts. `mem_rd_en`=0, `mem_rd_addr`=0, `pix_valid`=0, `pix_data`=0.
- With coordinate accepted in cycle T:
  - `mem_rd_en` is high in T+1..T+4.
  - p11 data arrives in T+4+`MEM_LATENCY`.
  - BLEND occurs in T+5+`MEM_LATENCY`.
  - `pix_valid` rises in T+6+`MEM_LATENCY` (T+8 at defaults).
- Out-of-range coordinate: `pix_valid` in T+1 with `pix_data`=0.
- Minimum accept interval at defaults with `pix_ready` held high: 9 cycles.
- `mem_rd_en` is never high outside FETCH. `mem_rd_addr` holds its last value when `mem_rd_en` is low.

## Test plan
- Memory model returns addr[7:0], width=8, height=6, coordinate (3,2), fracs 0 → reads at 19,20,27,28 in T+1..T+4; `pix_data`=19 with `pix_valid` at T+8.
- Neighbourhood 10,20,30,40, both fracs 0x8000 → `pix_data`=25.
- Edge clamp: (7,5), width=8, height=6 → all four addresses are 47; output equals that pixel.
- Out of range: `src_x`=8, width=8 → no `mem_rd_en`; `pix_valid` at T+1 with `pix_data`=0.
- Backpressure: `pix_ready` low for 5 cycles in OUT → `pix_data` stable, `coord_ready`=0 throughout. After `pix_ready` goes high, `coord_ready`=1 on the next cycle.
- `rst` pulsed in the 2nd FETCH cycle → `mem_rd_en`=0 on the next cycle, no `pix_valid` from stale returns, and the next transaction completes correctly.
